// File: rtl/bwt_pkg.sv
// Shared types and default sizing for the BWT engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bwt_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_MAX_LEN = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMP    = 2'd1,
    STORE  = 2'd2,
    STREAM = 2'd3
  } bwt_state_t;

endpackage

// File: rtl/bwt_rot_cmp.sv
// Unsigned comparison of one symbol of rotation j (sym_a) against rotation i (sym_b).
// Latency: combinational.
// Backpressure: none.
// Ports: sym_a/sym_b symbols in; lt/eq/gt mutually exclusive flags out (a<b, a==b, a>b).
module bwt_rot_cmp
  import bwt_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] sym_a,
  input  logic [DATA_W-1:0] sym_b,
  output logic              lt,
  output logic              eq,
  output logic              gt
);

  assign lt = (sym_a <  sym_b);
  assign eq = (sym_a == sym_b);
  assign gt = (sym_a >  sym_b);

endmodule

// File: rtl/bwt_engine.sv
// Burrows-Wheeler transform of a loaded string by rank counting of every rotation.
// Latency: start to first out_valid is at most length*(length*length+1)+2 cycles.
// Backpressure: output holds outstring/out_last while out_valid && !out_ready.
// Ports: clk/rst (sync, active-high); en/adr/in_string load the symbol buffer in IDLE;
//        length/start launch a transform; busy/err status; outstring/out_valid/out_ready/
//        out_last stream the result in rank order; primary_idx/done_flag report completion.
module bwt_engine
  import bwt_pkg::*;
#(
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int MAX_LEN = DEF_MAX_LEN,
  localparam int ADR_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADR_W-1:0]  adr,
  input  logic [DATA_W-1:0] in_string,
  input  logic [ADR_W:0]    length,
  input  logic              start,
  output logic              busy,
  output logic [DATA_W-1:0] outstring,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [ADR_W-1:0]  primary_idx,
  output logic              done_flag,
  output logic              err
);

  localparam logic [ADR_W:0]   MAX_LEN_L = (ADR_W+1)'(MAX_LEN);
  localparam logic [ADR_W:0]   LEN_ONE   = (ADR_W+1)'(1);
  localparam logic [ADR_W-1:0] ADR_ONE   = ADR_W'(1);

  bwt_state_t state, state_nxt;

  logic [DATA_W-1:0] sbuf [MAX_LEN];
  logic [DATA_W-1:0] obuf [MAX_LEN];

  logic [ADR_W:0]   len_q;
  logic [ADR_W-1:0] i_q, j_q, k_q;   // rotation under rank, rotation compared, symbol offset
  logic [ADR_W-1:0] pi_q, pj_q;      // buffer positions (i+k) and (j+k), wrapped
  logic [ADR_W-1:0] rank_q, rd_q;

  logic [ADR_W:0]   len_m1;
  logic             last_i, last_j, last_k, last_rd;
  logic             start_ok, adr_ok;
  logic             sym_lt, sym_eq, sym_gt;
  logic             self_pair, pair_done, rank_inc;
  logic [ADR_W-1:0] prev_pos;

  // Position advance modulo the string length without a divider.
  function automatic logic [ADR_W-1:0] wrap_inc(input logic [ADR_W-1:0] p,
                                                input logic [ADR_W:0]   n);
    logic [ADR_W:0] s;
    s = {1'b0, p} + LEN_ONE;
    return (s == n) ? '0 : s[ADR_W-1:0];
  endfunction

  assign len_m1  = len_q - LEN_ONE;
  assign last_i  = ({1'b0, i_q}  == len_m1);
  assign last_j  = ({1'b0, j_q}  == len_m1);
  assign last_k  = ({1'b0, k_q}  == len_m1);
  assign last_rd = ({1'b0, rd_q} == len_m1);

  assign adr_ok   = ({1'b0, adr} < MAX_LEN_L);
  assign start_ok = start && (state == IDLE) && (length != '0) && (length <= MAX_LEN_L);

  bwt_rot_cmp #(.DATA_W(DATA_W)) u_cmp (
    .sym_a (sbuf[pj_q]),
    .sym_b (sbuf[pi_q]),
    .lt    (sym_lt),
    .eq    (sym_eq),
    .gt    (sym_gt)
  );

  // A pair finishes on the self pair, the first mismatch, or a full-length match.
  assign self_pair = (j_q == i_q);
  assign pair_done = self_pair || sym_lt || sym_gt || last_k;
  assign rank_inc  = !self_pair && (sym_lt || (sym_eq && last_k && (j_q < i_q)));

  // Symbol preceding rotation i in the cyclic string: its last symbol.
  assign prev_pos = (i_q == '0) ? len_m1[ADR_W-1:0] : (i_q - ADR_ONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    out_valid = 1'b0;
    out_last  = 1'b0;
    outstring = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_ok) state_nxt = CMP;
      end
      CMP: begin
        if (pair_done && last_j) state_nxt = STORE;
      end
      STORE: begin
        state_nxt = last_i ? STREAM : CMP;
      end
      STREAM: begin
        out_valid = 1'b1;
        out_last  = last_rd;
        outstring = obuf[rd_q];
        if (out_ready && last_rd) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Buffers are plain register arrays; contents survive reset.
  always_ff @(posedge clk) begin
    if (en && (state == IDLE) && adr_ok) sbuf[adr] <= in_string;
    if (state == STORE) obuf[rank_q] <= sbuf[prev_pos];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      pi_q        <= '0;
      pj_q        <= '0;
      rank_q      <= '0;
      rd_q        <= '0;
      primary_idx <= '0;
      done_flag   <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= start && !start_ok;
      case (state)
        IDLE: begin
          if (start_ok) begin
            len_q     <= length;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            pi_q      <= '0;
            pj_q      <= '0;
            rank_q    <= '0;
            done_flag <= 1'b0;
          end
        end
        CMP: begin
          if (pair_done) begin
            if (rank_inc) rank_q <= rank_q + ADR_ONE;
            if (!last_j) begin
              // j+1 <= length-1 here, so no wrap is needed.
              j_q  <= j_q + ADR_ONE;
              k_q  <= '0;
              pi_q <= i_q;
              pj_q <= j_q + ADR_ONE;
            end
          end else begin
            k_q  <= k_q + ADR_ONE;
            pi_q <= wrap_inc(pi_q, len_q);
            pj_q <= wrap_inc(pj_q, len_q);
          end
        end
        STORE: begin
          if (i_q == '0) primary_idx <= rank_q;
          if (last_i) begin
            rd_q      <= '0;
            done_flag <= 1'b1;
          end else begin
            i_q    <= i_q + ADR_ONE;
            j_q    <= '0;
            k_q    <= '0;
            pi_q   <= i_q + ADR_ONE;
            pj_q   <= '0;
            rank_q <= '0;
          end
        end
        STREAM: begin
          if (out_ready && !last_rd) rd_q <= rd_q + ADR_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bwt_engine.sv
// Directed bench for bwt_engine: known BWT vectors, stalls, errors and reset.
// Latency: n/a.
// Backpressure: drives out_ready with fixed patterns.
module tb_bwt_engine;

  logic       clk = 1'b0;
  logic       rst, en, start, out_ready;
  logic [5:0] adr;
  logic [7:0] in_string;
  logic [6:0] length;
  logic       busy, out_valid, out_last, done_flag, err;
  logic [7:0] outstring;
  logic [5:0] primary_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bwt_engine #(.DATA_W(8), .MAX_LEN(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .adr         (adr),
    .in_string   (in_string),
    .length      (length),
    .start       (start),
    .busy        (busy),
    .outstring   (outstring),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .primary_idx (primary_idx),
    .done_flag   (done_flag),
    .err         (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) begin
      en        = 1'b1;
      adr       = 6'(i);
      in_string = s[i];
      tick();
    end
    en = 1'b0;
  endtask

  task automatic start_len(input int n);
    length = 7'(n);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0,1 per cycle.
  task automatic stream(input string exp, input int pidx, input int mode, input bit start_on_last);
    int         n;
    int         beat;
    int         cyc;
    int         first;
    int         bound;
    bit         stalled;
    logic [7:0] hs;
    logic       hl;
    n       = exp.len();
    beat    = 0;
    cyc     = 0;
    first   = -1;
    stalled = 1'b0;
    hs      = '0;
    hl      = 1'b0;
    bound   = n * (n * n + 1) + 2;
    while (beat < n && cyc < 3000) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      start     = 1'b0;
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (stalled) begin
          chk("hold_sym", 32'(outstring), 32'(hs));
          chk("hold_last", 32'(out_last), 32'(hl));
        end
        if (out_ready) begin
          chk("sym", 32'(outstring), 32'(exp[beat]));
          chk("last", 32'(out_last), (beat == n - 1) ? 32'd1 : 32'd0);
          chk("done_flag", 32'(done_flag), 32'd1);
          if (start_on_last && beat == n - 1) begin
            length = 7'(n);
            start  = 1'b1;
          end
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hs      = outstring;
          hl      = out_last;
        end
      end
      tick();
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    chk("beats", 32'(beat), 32'(n));
    chk("latency", (first >= 0 && first <= bound) ? 32'd1 : 32'd0, 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("valid_end", 32'(out_valid), 32'd0);
    chk("done_end", 32'(done_flag), 32'd1);
    chk("pidx", 32'(primary_idx), 32'(pidx));
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    adr       = '0;
    in_string = '0;
    length    = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_done", 32'(done_flag), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pidx", 32'(primary_idx), 32'd0);
    rst = 1'b0;
    tick();

    // banana; a second start and a write during CMP are both ignored,
    // as is a start coinciding with the last handshake.
    load("banana");
    start_len(6);
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_err", 32'(err), 32'd0);
    start     = 1'b1;
    length    = 7'd6;
    en        = 1'b1;
    adr       = 6'd0;
    in_string = 8'h7a;
    tick();
    start = 1'b0;
    en    = 1'b0;
    chk("cmp_busy", 32'(busy), 32'd1);
    stream("nnbaaa", 3, 0, 1'b1);

    // Same buffer, stalling consumer.
    start_len(6);
    chk("restart_done_clr", 32'(done_flag), 32'd0);
    stream("nnbaaa", 3, 1, 1'b0);

    // Reset in the middle of CMP, then reload and rerun.
    start_len(6);
    repeat (9) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done_flag), 32'd0);
    chk("mrst_pidx", 32'(primary_idx), 32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    load("banana");
    start_len(6);
    stream("nnbaaa", 3, 0, 1'b0);

    // Single symbol.
    load("x");
    start_len(1);
    stream("x", 0, 0, 1'b0);

    // All-equal rotations resolved by index.
    load("aaaa");
    start_len(4);
    stream("aaaa", 0, 0, 1'b0);

    // Illegal lengths.
    start_len(0);
    chk("len0_err", 32'(err), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    tick();
    chk("err_pulse", 32'(err), 32'd0);
    start_len(65);
    chk("len65_err", 32'(err), 32'd1);
    chk("len65_busy", 32'(busy), 32'd0);
    tick();

    // Maximum length is accepted.
    start_len(64);
    chk("len64_busy", 32'(busy), 32'd1);
    chk("len64_err", 32'(err), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("len64_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bwt_engine.md
BWT_ENGINE -- requirements
Module: bwt_engine

Interface
REQ-001 Parameter DATA_W, default 8, symbol width in bits.
REQ-002 Parameter MAX_LEN, default 64, maximum string length in symbols; ADR_W = clog2(MAX_LEN) shall size addresses.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 en  in  1  load strobe; writes in_string into symbol buffer at adr.
REQ-006 adr  in  ADR_W  load address.
REQ-007 in_string  in  DATA_W  symbol to load.
REQ-008 length  in  ADR_W+1  string length, sampled on start.
REQ-009 start  in  1  one-cycle pulse beginning the transform.
REQ-010 busy  out  1  high from start acceptance until the last output symbol is accepted.
REQ-011 outstring  out  DATA_W  BWT output symbol, rank order.
REQ-012 out_valid / out_ready / out_last  out/in/out  1 each  output stream handshake; out_last marks rank length-1.
REQ-013 primary_idx  out  ADR_W  rank of the unrotated string; valid while done_flag high.
REQ-014 done_flag  out  1  high from the first output beat until the next start or rst.
REQ-015 err  out  1  one-cycle pulse on a rejected start.

Function
REQ-016 States: IDLE, CMP, STORE, STREAM; IDLE->CMP on accepted start, CMP->STORE when all j are compared for the current i, STORE->CMP (i+1) or STREAM after i=length-1, STREAM->IDLE on the out_last handshake.
REQ-017 Writes (en) shall be accepted only in IDLE; en while busy is ignored.
REQ-018 start shall be accepted only in IDLE with 1<=length<=MAX_LEN; otherwise no state change and err=1 for one cycle.
REQ-019 Rotation i shall be s[(i+k) mod length], k=0..length-1; index wrap shall use compare-and-subtract, not division.
REQ-020 CMP: for each j != i, compare rotation j against rotation i, one symbol pair per cycle, stopping at the first mismatch; rank_i increments if rot_j < rot_i (unsigned), or if all length symbols are equal and j < i.
REQ-021 Pair j=i shall consume exactly one cycle and never increment rank_i.
REQ-022 STORE (one cycle): outbuf[rank_i] = s[(i+length-1) mod length]; if i=0, primary_idx register = rank_i.
REQ-023 STREAM: outbuf[0..length-1] presented in order; the symbol advances only when out_valid&&out_ready; outstring and out_last shall hold stable while out_valid&&!out_ready.
REQ-024 Worst-case latency start->first out_valid shall be <= length*(length*length+1)+2 cycles.
REQ-025 length=1: output = s[0], primary_idx=0, out_last on the first beat.
REQ-026 start asserted in the same cycle as the final output handshake is ignored (block still busy).

Reset
REQ-027 rst shall force IDLE and clear busy, out_valid, out_last, done_flag, err, primary_idx and all counters to 0, including mid-CMP or mid-STREAM.
REQ-028 Symbol buffer and outbuf contents are not reset; a new load plus start is required after rst.

Structure
REQ-029 Shared package bwt_pkg holds the state enum and default DATA_W/MAX_LEN constants.
REQ-030 One sub-module, bwt_rot_cmp: combinational symbol comparator returning lt/eq/gt for a symbol pair.
REQ-031 Buffers are register arrays with asynchronous read; no external memory macro.

Verification
REQ-032 Load "banana", length=6, start, out_ready=1 -> stream "nnbaaa", out_last on 6th beat, primary_idx=3.
REQ-033 Load "aaaa", length=4 -> stream "aaaa", primary_idx=0 (index tie-break).
REQ-034 Load "x", length=1 -> single beat 'x', out_last=1, primary_idx=0.
REQ-035 "banana" with out_ready toggled 1-0-0-1 each cycle -> same 6 symbols, no drop/duplicate, outstring stable while stalled.
REQ-036 start with length=0 or MAX_LEN+1 -> err pulse, busy stays 0; start during CMP -> ignored.
REQ-037 rst pulsed mid-CMP on "banana" -> next cycle busy=0, done_flag=0; reload+start yields "nnbaaa", primary_idx=3.
